// File: rtl/pixel_packer.sv
// pixel_packer
//   Packs a stream of 8-bit pixels into 32-bit little-endian words (first
//   pixel of a group in [7:0]) and writes them to BRAM port A at
//   incrementing addresses starting from 0 for every frame.
//
//   Optional build feature (macro PIXEL_PACKER_FLUSH_EN):
//     defined   - a frame ending mid-word writes the partial word, with
//                 unused upper lanes filled with PAD_BYTE.
//     undefined - a frame ending mid-word drops the partial word.
//
// Parameters:
//   ADDR_W    BRAM word address width
//   DEPTH     number of writable words (DEPTH <= 2**ADDR_W)
//   PAD_BYTE  fill value for unused lanes of a flushed word
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       arms a new frame (honoured only when idle)
//   pix_in      pixel data
//   pix_valid   pix_in valid this cycle
//   pix_last    pix_in is the final pixel of the frame
//   pix_ready   a pixel is accepted this cycle when pix_valid is high
//   dina        BRAM write data (registered)
//   addra       BRAM write address (registered)
//   wea         BRAM write enable, one cycle per word
//   frame_done  one-cycle end-of-frame pulse
//   overflow    sticky: memory filled before pix_last
//   word_count  words written in the current frame
module pixel_packer #(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned DEPTH    = 16384,
    parameter logic [7:0]  PAD_BYTE = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        pix_in,
    input  logic              pix_valid,
    input  logic              pix_last,
    output logic              pix_ready,
    output logic [31:0]       dina,
    output logic [ADDR_W-1:0] addra,
    output logic              wea,
    output logic              frame_done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [1:0]          lane_q, lane_d;
    logic [7:0]          l0_q, l0_d;
    logic [7:0]          l1_q, l1_d;
    logic [7:0]          l2_q, l2_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     wc_q, wc_d;
    logic                ovf_q, ovf_d;
    logic [31:0]         dina_q, dina_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;
    logic                wea_q, wea_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            l0_q    <= '0;
            l1_q    <= '0;
            l2_q    <= '0;
            addr_q  <= '0;
            wc_q    <= '0;
            ovf_q   <= 1'b0;
            dina_q  <= '0;
            addra_q <= '0;
            wea_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            l0_q    <= l0_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
            ovf_q   <= ovf_d;
            dina_q  <= dina_d;
            addra_q <= addra_d;
            wea_q   <= wea_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        l0_d    = l0_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        addr_d  = addr_q;
        wc_d    = wc_q;
        ovf_d   = ovf_q;
        dina_d  = dina_q;
        addra_d = addra_q;
        wea_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                    lane_d  = '0;
                    addr_d  = '0;
                    wc_d    = '0;
                    ovf_d   = 1'b0;
                end
            end

            S_FILL: begin
                if (pix_valid) begin
                    if (lane_q == 2'd3) begin
                        // Lane-3 pixel completes the word directly from the
                        // input, so only lanes 0..2 need storage.
                        wea_d   = 1'b1;
                        dina_d  = {pix_in, l2_q, l1_q, l0_q};
                        addra_d = addr_q;
                        addr_d  = addr_q + ADDR_W'(1);
                        wc_d    = wc_q + (ADDR_W + 1)'(1);
                        lane_d  = '0;
                        if (pix_last) begin
                            state_d = S_DONE;
                        end else if (addr_q == LAST_ADDR) begin
                            state_d = S_DONE;
                            ovf_d   = 1'b1;
                        end
                    end else begin
                        case (lane_q)
                            2'd0:    l0_d = pix_in;
                            2'd1:    l1_d = pix_in;
                            default: l2_d = pix_in;
                        endcase
                        lane_d = lane_q + 2'd1;
                        if (pix_last) begin
`ifdef PIXEL_PACKER_FLUSH_EN
                            wea_d   = 1'b1;
                            addra_d = addr_q;
                            addr_d  = addr_q + ADDR_W'(1);
                            wc_d    = wc_q + (ADDR_W + 1)'(1);
                            case (lane_q)
                                2'd0:    dina_d = {PAD_BYTE, PAD_BYTE, PAD_BYTE, pix_in};
                                2'd1:    dina_d = {PAD_BYTE, PAD_BYTE, pix_in, l0_q};
                                default: dina_d = {PAD_BYTE, pix_in, l1_q, l0_q};
                            endcase
`else
                            // Partial word is dropped: no write.
`endif
                            lane_d  = '0;
                            state_d = S_DONE;
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pix_ready  = (state_q == S_FILL);
    assign frame_done = (state_q == S_DONE);
    assign overflow   = ovf_q;
    assign word_count = wc_q;
    assign dina       = dina_q;
    assign addra      = addra_q;
    assign wea        = wea_q;

endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer
//   Directed bench for pixel_packer with a small memory (DEPTH=4) so the
//   full-memory boundary is reachable. Expectations follow the build's
//   PIXEL_PACKER_FLUSH_EN setting.
module tb_pixel_packer;

    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    pix_in;
    logic          pix_valid;
    logic          pix_last;
    logic          pix_ready;
    logic [31:0]   dina;
    logic [AW-1:0] addra;
    logic          wea;
    logic          frame_done;
    logic          overflow;
    logic [AW:0]   word_count;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] q_fd[$];

    always #5 clk = ~clk;

    pixel_packer #(
        .ADDR_W  (AW),
        .DEPTH   (4),
        .PAD_BYTE(8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_last  (pix_last),
        .pix_ready (pix_ready),
        .dina      (dina),
        .addra     (addra),
        .wea       (wea),
        .frame_done(frame_done),
        .overflow  (overflow),
        .word_count(word_count)
    );

    // Log every BRAM write, sampled mid-cycle.
    always @(negedge clk) begin
        if (wea) begin
            q_addr.push_back(32'(addra));
            q_data.push_back(dina);
            q_fd.push_back(32'(frame_done));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] fd);
        logic [31:0] oa, od, ofd;
        oa  = (idx < q_addr.size()) ? q_addr[idx] : 32'hDEAD_BEEF;
        od  = (idx < q_data.size()) ? q_data[idx] : 32'hDEAD_BEEF;
        ofd = (idx < q_fd.size())   ? q_fd[idx]   : 32'hDEAD_BEEF;
        chk({tag, "_addr"}, oa, a);
        chk({tag, "_data"}, od, d);
        chk({tag, "_fd"},   ofd, fd);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p, input logic l);
        pix_in    = p;
        pix_valid = 1'b1;
        pix_last  = l;
        tick();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_fd.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        pix_in    = 8'h00;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_pix_ready",  32'(pix_ready), 32'd0);
        chk("rst_dina",       dina, 32'd0);
        chk("rst_addra",      32'(addra), 32'd0);
        chk("rst_wea",        32'(wea), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overflow",   32'(overflow), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ignores_valid_ready", 32'(pix_ready), 32'd0);

        // Full frame, back-to-back pixels
        clear_log();
        pulse_start();
        chk("t1_ready_after_start", 32'(pix_ready), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), i == 8);
        end
        chk("t1_frame_done", 32'(frame_done), 32'd1);
        chk("t1_wea_last",   32'(wea), 32'd1);
        chk("t1_addra_last", 32'(addra), 32'd1);
        chk("t1_dina_last",  dina, 32'h0807_0605);
        chk("t1_word_count", 32'(word_count), 32'd2);
        chk("t1_ready_done", 32'(pix_ready), 32'd0);
        start = 1'b1;                       // start during DONE must be ignored
        tick();
        start = 1'b0;
        chk("t1_done_start_ignored", 32'(pix_ready), 32'd0);
        chk("t1_fd_one_cycle",       32'(frame_done), 32'd0);
        chk("t1_nwrites",            32'(q_addr.size()), 32'd2);
        chk_wr("t1_w0", 0, 32'd0, 32'h0403_0201, 32'd0);
        chk_wr("t1_w1", 1, 32'd1, 32'h0807_0605, 32'd1);
        tick();

        // Bubbles every other cycle
        clear_log();
        pulse_start();
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), i == 8);
            if (i == 4) begin
                chk("t2_wea_after_p4",  32'(wea), 32'd1);
                chk("t2_dina_after_p4", dina, 32'h0403_0201);
                chk("t2_addr_after_p4", 32'(addra), 32'd0);
            end
            if (i != 8) begin
                tick();
            end
        end
        chk("t2_frame_done", 32'(frame_done), 32'd1);
        chk("t2_word_count", 32'(word_count), 32'd2);
        tick();
        chk("t2_nwrites", 32'(q_addr.size()), 32'd2);
        chk_wr("t2_w1", 1, 32'd1, 32'h0807_0605, 32'd1);
        tick();

        // Partial final word, last pixel in lane 0
        clear_log();
        pulse_start();
        for (int i = 1; i <= 5; i++) begin
            send(8'(i), i == 5);
        end
        chk("t3_frame_done", 32'(frame_done), 32'd1);
`ifdef PIXEL_PACKER_FLUSH_EN
        chk("t3_wea",        32'(wea), 32'd1);
        chk("t3_dina",       dina, 32'h0000_0005);
        chk("t3_addra",      32'(addra), 32'd1);
        chk("t3_word_count", 32'(word_count), 32'd2);
        tick();
        chk("t3_nwrites",    32'(q_addr.size()), 32'd2);
`else
        chk("t3_wea",        32'(wea), 32'd0);
        chk("t3_word_count", 32'(word_count), 32'd1);
        tick();
        chk("t3_nwrites",    32'(q_addr.size()), 32'd1);
`endif
        tick();

        // Partial final word, last pixel in lane 2
        clear_log();
        pulse_start();
        send(8'h0A, 1'b0);
        send(8'h0B, 1'b0);
        send(8'h0C, 1'b1);
        chk("t3b_frame_done", 32'(frame_done), 32'd1);
`ifdef PIXEL_PACKER_FLUSH_EN
        chk("t3b_wea",        32'(wea), 32'd1);
        chk("t3b_dina",       dina, 32'h000C_0B0A);
        chk("t3b_addra",      32'(addra), 32'd0);
        chk("t3b_word_count", 32'(word_count), 32'd1);
`else
        chk("t3b_wea",        32'(wea), 32'd0);
        chk("t3b_word_count", 32'(word_count), 32'd0);
`endif
        tick();
        tick();

        // Overflow: 16 pixels fill DEPTH=4 without pix_last
        clear_log();
        pulse_start();
        for (int i = 1; i <= 16; i++) begin
            send(8'(i), 1'b0);
        end
        chk("t4_frame_done", 32'(frame_done), 32'd1);
        chk("t4_wea",        32'(wea), 32'd1);
        chk("t4_addra",      32'(addra), 32'd3);
        chk("t4_overflow",   32'(overflow), 32'd1);
        chk("t4_word_count", 32'(word_count), 32'd4);
        chk("t4_ready_done", 32'(pix_ready), 32'd0);
        pix_in    = 8'hFF;
        pix_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        pix_valid = 1'b0;
        chk("t4_ready_after",    32'(pix_ready), 32'd0);
        chk("t4_overflow_stick", 32'(overflow), 32'd1);
        chk("t4_nwrites",        32'(q_addr.size()), 32'd4);
        chk_wr("t4_w0", 0, 32'd0, 32'h0403_0201, 32'd0);
        chk_wr("t4_w3", 3, 32'd3, 32'h100F_0E0D, 32'd1);
        pulse_start();
        chk("t4_restart_ovf_clr", 32'(overflow), 32'd0);
        chk("t4_restart_ready",   32'(pix_ready), 32'd1);
        chk("t4_restart_wc",      32'(word_count), 32'd0);
        send(8'h21, 1'b0);
        send(8'h22, 1'b0);
        send(8'h23, 1'b0);
        send(8'h24, 1'b1);
        chk("t4_restart_addra", 32'(addra), 32'd0);
        chk("t4_restart_dina",  dina, 32'h2423_2221);
        chk("t4_restart_wc1",   32'(word_count), 32'd1);
        tick();
        tick();

        // pix_last coinciding with the write at DEPTH-1: no overflow
        pulse_start();
        for (int i = 1; i <= 16; i++) begin
            send(8'(i), i == 16);
        end
        chk("t4b_frame_done", 32'(frame_done), 32'd1);
        chk("t4b_addra",      32'(addra), 32'd3);
        chk("t4b_overflow",   32'(overflow), 32'd0);
        chk("t4b_word_count", 32'(word_count), 32'd4);
        tick();
        tick();

        // Reset mid-word
        clear_log();
        pulse_start();
        for (int i = 1; i <= 6; i++) begin
            send(8'(i), 1'b0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_pix_ready",  32'(pix_ready), 32'd0);
        chk("t5_dina",       dina, 32'd0);
        chk("t5_addra",      32'(addra), 32'd0);
        chk("t5_wea",        32'(wea), 32'd0);
        chk("t5_frame_done", 32'(frame_done), 32'd0);
        chk("t5_word_count", 32'(word_count), 32'd0);
        chk("t5_nwrites",    32'(q_addr.size()), 32'd1);
        pulse_start();
        send(8'h11, 1'b0);
        send(8'h12, 1'b0);
        send(8'h13, 1'b0);
        send(8'h14, 1'b1);
        chk("t5_new_wea",   32'(wea), 32'd1);
        chk("t5_new_addra", 32'(addra), 32'd0);
        chk("t5_new_dina",  dina, 32'h1413_1211);
        tick();
        tick();

        // start pulsed in FILL is ignored
        clear_log();
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        pulse_start();
        chk("t6_ready_kept", 32'(pix_ready), 32'd1);
        for (int i = 3; i <= 8; i++) begin
            send(8'(i), i == 8);
        end
        chk("t6_word_count", 32'(word_count), 32'd2);
        tick();
        chk("t6_nwrites", 32'(q_addr.size()), 32'd2);
        chk_wr("t6_w0", 0, 32'd0, 32'h0403_0201, 32'd0);
        chk_wr("t6_w1", 1, 32'd1, 32'h0807_0605, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pixel_packer.md
# pixel_packer

Write-side counterpart of the BRAM word unpacker. The block accepts a stream of 8-bit pixels, packs four consecutive pixels into one 32-bit word, and writes each word into block RAM port A at incrementing addresses. Byte order is little-endian: the first pixel of a group goes to [7:0] and the fourth to [31:24]. Reading the BRAM back through the unpacker therefore returns the pixels on o1..o4 in their original stream order.

## Interface
Parameters:
- ADDR_W, 14, width of the BRAM word address.
- DEPTH, 16384, number of 32-bit words available; must satisfy DEPTH ≤ 2^ADDR_W.
- PAD_BYTE, 8'h00, fill value for unused lanes of a flushed partial word.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that arms a new frame. Honoured only in IDLE.
- pix_in  in  8  pixel data.
- pix_valid  in  1  pix_in is valid this cycle.
- pix_last  in  1  qualifies pix_in as the final pixel of the frame.
- pix_ready  out  1  block accepts a pixel this cycle.
- dina  out  32  BRAM write data.
- addra  out  ADDR_W  BRAM write address.
- wea  out  1  BRAM write enable, one cycle per word.
- frame_done  out  1  one-cycle pulse marking the end of a frame.
- overflow  out  1  sticky flag: memory filled before pix_last. Cleared by rst or by an accepted start.
- word_count  out  ADDR_W+1  number of words written in the current frame.

## Operation
- A pixel is accepted when pix_valid && pix_ready on a rising edge.
- States:
  - IDLE: pix_ready=0; pix_valid is ignored.
    - On start: go to FILL, and clear lane to 0, address to 0, word_count and overflow.
  - FILL: pix_ready=1.
    - Each accepted pixel is stored into byte lane `lane` (0..3), then lane increments and wraps 3→0.
    - Accepting a pixel in lane 3 registers a write: dina = {p3,p2,p1,p0}, addra = current word address, wea=1. The address and word_count then increment.
    - If pix_last is accepted, or the write just registered targets address DEPTH-1, go to DONE.
  - DONE: lasts exactly one cycle; frame_done=1 and pix_ready=0. Next state is IDLE.
- pix_last accepted in lane 3: normal write, then DONE.
- pix_last accepted in lanes 0..2: handled per Configuration.
- Write at address DEPTH-1 without pix_last: go to DONE and set overflow=1. Later pixels are not accepted.
- pix_last together with the write at DEPTH-1: go to DONE; overflow stays 0.
- start is ignored in FILL and DONE.
- Bubbles (pix_valid=0) in FILL hold all state; lane contents are preserved.
- rst in any state, including mid-word: return to IDLE and discard the partial word. No write is issued.

## Timing
- Reset values: pix_ready=0, dina=0, addra=0, wea=0, frame_done=0, overflow=0, word_count=0, lane=0.
- Write latency: wea, dina and addra are registered. They are valid in the cycle after the edge that accepts the completing pixel, and wea is high for exactly that one cycle.
- addra holds the written address during the wea cycle. Consecutive words go to consecutive addresses, starting at 0 for each frame.
- Final word of a frame: its wea cycle coincides with the DONE cycle, so frame_done=1 and wea=1 together.
- word_count is updated on the same edge as wea rising, so it already includes the word being written.
- pix_ready rises in the cycle after start is accepted and falls in the DONE cycle. pix_ready is not a function of pix_valid.
- Sustained throughput: one pixel per clock, i.e. one BRAM write every 4 clocks.

## Configuration
- Macro: PIXEL_PACKER_FLUSH_EN.
- Defined: pix_last accepted in lanes 0..2 writes the partial word. Lanes above the last one are filled with PAD_BYTE, and that write counts in word_count.
- Undefined: the partial word is dropped with no write. DONE still occurs and frame_done still pulses, with wea=0.
- Behaviour for pix_last in lane 3 is identical in both builds.

## Test plan
- Full frame:
  - Stimulus: start, then pixels 01..08 back-to-back, pix_last on 08.
  - Response: wea at addr 0 with 0x04030201, then at addr 1 with 0x08070605. frame_done coincides with the second write; word_count=2.
- Pixel bubbles:
  - Stimulus: same 8 pixels with pix_valid low every other cycle.
  - Response: identical writes and data; the first write occurs 1 cycle after accepting pixel 04.
- Partial final word:
  - Stimulus: pixels 01..05, pix_last on 05.
  - With FLUSH_EN: second write 0x00000005 at addr 1, word_count=2.
  - Without FLUSH_EN: exactly one write; frame_done pulses with wea=0; word_count=1.
- Overflow:
  - Stimulus: DEPTH=4, 20 pixels without pix_last.
  - Response: 4 writes at addrs 0..3; overflow=1; frame_done with the addr-3 write; pix_ready=0 afterwards. The next start clears overflow and restarts at addr 0.
- Reset mid-word:
  - Stimulus: after pixels 01..06, assert rst for 1 cycle.
  - Response: no write for 05/06; all outputs return to reset values. A new start and pixels 11..14 write 0x14131211 at addr 0.
- Ignored start:
  - Stimulus: start pulsed in FILL after pixel 02.
  - Response: no effect; lane and address continue unchanged.
